// File: rtl/rx_iq_byte_packer.sv
// Receive-path I/Q byte packer: queues 24-bit I/Q sample pairs from the FIR
// output in a small FIFO and serializes each pair as six bytes, MSB first,
// I before Q, over a valid/ready byte stream.
module rx_iq_byte_packer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_strobe,
  input  logic [23:0]               in_I,
  input  logic [23:0]               in_Q,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  typedef enum logic {StIdle, StSend} state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic [47:0]    shreg_q;
  logic           overflow_q;
  logic [47:0]    mem [DEPTH];

  logic           full;
  logic           wr_en;
  logic           drop;
  logic           pop;

  // Full test uses the pre-edge level, so a same-cycle pop never makes room.
  assign full  = (level_q == FullLevel);
  assign wr_en = in_strobe && !full;
  assign drop  = in_strobe && full;

  // Serializer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Serializer next state: load from the FIFO when idle, or back-to-back after the last byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = StSend;
          idx_d   = 3'd0;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (idx_q == 3'd5) begin
            idx_d = 3'd0;
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  // Serializer outputs: byte select from the shift register, zeroed while idle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (state_q == StSend) begin
      out_valid = 1'b1;
      out_last  = (idx_q == 3'd5);
      case (idx_q)
        3'd0:    out_data = shreg_q[47:40];
        3'd1:    out_data = shreg_q[39:32];
        3'd2:    out_data = shreg_q[31:24];
        3'd3:    out_data = shreg_q[23:16];
        3'd4:    out_data = shreg_q[15:8];
        3'd5:    out_data = shreg_q[7:0];
        default: out_data = 8'h00;
      endcase
    end
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[wr_ptr_q] <= {in_I, in_Q};
    end
  end

  // FIFO pointers, occupancy, shift-register load and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        shreg_q  <= mem[rd_ptr_q];
      end
      unique case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A drop wins over a coincident clear.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rx_iq_byte_packer.sv
// Bench for rx_iq_byte_packer: directed stimulus pushes expected bytes into a
// scoreboard queue; a negedge monitor pops and compares on every transfer.
module tb_rx_iq_byte_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_strobe = 1'b0;
  logic [23:0]   in_I = '0;
  logic [23:0]   in_Q = '0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clear_ovf = 1'b0;

  rx_iq_byte_packer #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_strobe (in_strobe),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #4 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  logic [8:0] sb[$];
  logic [8:0] e;
  bit         mon_en = 1'b0;
  int         run_cur = 0;
  int         last_run = 0;
  int         xfer_cnt = 0;
  int         max_lvl = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, hold stability, idle zeros, run length, peak level.
  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got byte %0h want none at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          check("byte", 64'(out_data), 64'(e[7:0]));
          check("last", 64'(out_last), 64'(e[8]));
        end
        xfer_cnt++;
      end
      if (!out_valid) begin
        check("idle_data", 64'(out_data), 64'd0);
        check("idle_last", 64'(out_last), 64'd0);
      end
      if (out_valid) begin
        run_cur++;
      end else if (run_cur > 0) begin
        last_run = run_cur;
        run_cur  = 0;
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_sample(input logic [23:0] i, input logic [23:0] q);
    logic [47:0] s;
    s = {i, q};
    for (int k = 0; k < 6; k++) begin
      sb.push_back({(k == 5), s[47-8*k -: 8]});
    end
  endtask

  task automatic strobe(input logic [23:0] i, input logic [23:0] q, input bit accept);
    in_I      = i;
    in_Q      = q;
    in_strobe = 1'b1;
    if (accept) push_sample(i, q);
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((out_valid || level != '0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(out_valid || level != '0), 64'd0);
    tick();
  endtask

  // Strobe into an empty idle block: valid with I[23:16] two cycles later, 6 contiguous bytes.
  task automatic latency_run(input logic [23:0] i, input logic [23:0] q);
    strobe(i, q, 1'b1);
    check("lat_n1_valid", 64'(out_valid), 64'd0);
    check("lat_n1_level", 64'(level), 64'd1);
    tick();
    check("lat_n2_valid", 64'(out_valid), 64'd1);
    check("lat_n2_data", 64'(out_data), 64'(i[23:16]));
    for (int k = 1; k < 6; k++) begin
      tick();
      check("lat_cont_valid", 64'(out_valid), 64'd1);
    end
    tick();
    check("lat_end_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_run", 64'(last_run), 64'd6);
  endtask

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    in_strobe = 1'b1;
    repeat (3) tick();
    in_strobe = 1'b0;
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);

    // Single sample
    out_ready = 1'b1;
    latency_run(24'h123456, 24'hABCDEF);

    // Three strobes two cycles apart: 18 contiguous bytes, peak level 2
    max_lvl = 0;
    strobe(24'hA1B2C3, 24'hD4E5F6, 1'b1);
    tick();
    strobe(24'h0F1E2D, 24'h3C4B5A, 1'b1);
    tick();
    strobe(24'h876543, 24'h210FED, 1'b1);
    drain(60);
    check("contig_run", 64'(last_run), 64'd18);
    check("contig_maxlvl", 64'(max_lvl), 64'd2);
    check("contig_sb", 64'(sb.size()), 64'd0);

    // Backpressure with DEPTH+2 strobes: last one dropped
    out_ready = 1'b0;
    for (int k = 0; k < int'(DEPTH) + 2; k++) begin
      strobe(24'h100000 + 24'(k), 24'h200000 + 24'(k * 3), (k <= int'(DEPTH)));
      if (k == int'(DEPTH)) check("ovf_before_drop", 64'(overflow), 64'd0);
    end
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_ovf", 64'(overflow), 64'd1);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_head", 64'(out_data), 64'h10);
    xfer_cnt = 0;
    out_ready = 1'b1;
    drain(100);
    check("full_xfers", 64'(xfer_cnt), 64'(6 * (DEPTH + 1)));
    check("full_sb", 64'(sb.size()), 64'd0);

    // Clear alone, then clear coinciding with a drop, then clear alone
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_alone", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    for (int k = 0; k < int'(DEPTH) + 1; k++) begin
      strobe(24'h3A0000 + 24'(k), 24'h5C0000 - 24'(k), 1'b1);
    end
    check("clr_pre_ovf", 64'(overflow), 64'd0);
    clear_ovf = 1'b1;
    strobe(24'hDEAD00, 24'hBEEF00, 1'b0);
    check("clr_with_drop", 64'(overflow), 64'd1);
    tick();
    clear_ovf = 1'b0;
    check("clr_next", 64'(overflow), 64'd0);
    xfer_cnt = 0;
    out_ready = 1'b1;
    drain(100);
    check("clr_xfers", 64'(xfer_cnt), 64'(6 * (DEPTH + 1)));

    // Ready toggling across one sample
    xfer_cnt = 0;
    out_ready = 1'b1;
    strobe(24'hC0FFEE, 24'h5EED01, 1'b1);
    n = 0;
    while (n < 40 && !(n > 0 && !out_valid && level == '0)) begin
      out_ready = !out_ready;
      tick();
      n++;
    end
    check("toggle_timeout", 64'(n < 40), 64'd1);
    out_ready = 1'b1;
    tick();
    check("toggle_xfers", 64'(xfer_cnt), 64'd6);
    check("toggle_sb", 64'(sb.size()), 64'd0);

    // Reset at byte index 3 with two queued samples
    strobe(24'h111111, 24'h2233AA, 1'b1);
    strobe(24'h444444, 24'h555555, 1'b1);
    strobe(24'h666666, 24'h777777, 1'b1);
    tick();
    tick();
    check("mid_byte3", 64'(out_data), 64'h22);
    check("mid_level", 64'(level), 64'd2);
    reset = 1'b1;
    in_I = 24'h999999;
    in_Q = 24'h888888;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    reset = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    sb.delete();
    tick();
    check("mid_idle_valid", 64'(out_valid), 64'd0);
    check("mid_idle_level", 64'(level), 64'd0);
    latency_run(24'hFEDCBA, 24'h013579);

    check("final_sb", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_iq_byte_packer.md
RX_IQ_BYTE_PACKER -- requirements
Module: rx_iq_byte_packer

Interface
REQ-001 Parameter: DEPTH, default 4, sample-FIFO depth in I/Q pairs; power of 2, range 2..16.
REQ-002 clock  in  1  122.88 MHz system clock; single clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_strobe  in  1  one-cycle pulse marking a valid I/Q sample from the receiver FIR output.
REQ-005 in_I  in  24  signed I sample, valid when in_strobe=1.
REQ-006 in_Q  in  24  signed Q sample, valid when in_strobe=1.
REQ-007 out_data  out  8  byte stream to the frame assembler.
REQ-008 out_valid  out  1  out_data holds a valid byte.
REQ-009 out_ready  in  1  consumer accepts the byte; a transfer occurs when out_valid=1 and out_ready=1.
REQ-010 out_last  out  1  high with the 6th (final) byte of each sample.
REQ-011 level  out  clog2(DEPTH)+1  number of samples held in the FIFO, excluding the sample being serialized.
REQ-012 overflow  out  1  sticky flag: a sample was dropped.
REQ-013 clear_ovf  in  1  one-cycle pulse that clears overflow.

Function
REQ-014 On in_strobe with level<DEPTH, {in_I,in_Q} SHALL be written to the FIFO at that clock edge.
REQ-015 On in_strobe with level==DEPTH, the sample SHALL be discarded and overflow set; the full test uses the pre-edge level, even if a pop occurs in the same cycle.
REQ-016 level SHALL change by +1 on write, -1 on pop, and 0 on simultaneous write and pop.
REQ-017 Serializer states: IDLE (out_valid=0) and SEND (out_valid=1), with byte index 0..5.
REQ-018 IDLE->SEND: when level>0, pop the head into the shift register, index=0; out_valid SHALL assert the next cycle.
REQ-019 Byte order in SEND: index0 I[23:16], 1 I[15:8], 2 I[7:0], 3 Q[23:16], 4 Q[15:8], 5 Q[7:0]; out_last=1 only at index 5.
REQ-020 Each transfer SHALL advance the index by 1; out_data, out_last and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 On transfer at index 5 with level>0, the next sample SHALL be popped in the same edge, staying in SEND at index 0 with no idle cycle.
REQ-022 On transfer at index 5 with level==0, the block SHALL return to IDLE and out_valid SHALL deassert the next cycle.
REQ-023 Latency: strobe in cycle N to an empty, idle block SHALL give out_valid=1 with byte I[23:16] in cycle N+2.
REQ-024 FIFO read and write pointers SHALL wrap modulo DEPTH; data order SHALL be strict FIFO.
REQ-025 Sustained throughput: one byte per clock when out_ready is held high.
REQ-026 overflow SHALL clear on clear_ovf; if clear_ovf and a drop coincide, overflow SHALL remain 1.
REQ-027 When out_valid=0, out_data and out_last SHALL be 0.

Reset
REQ-028 While reset=1: FIFO emptied, level=0, state IDLE, index=0, out_valid=0, out_data=0, out_last=0, overflow=0.
REQ-029 Reset mid-sample SHALL abandon that sample and all queued samples; in_strobe during reset SHALL be ignored.
REQ-030 The first sample accepted after reset deasserts SHALL obey REQ-023 latency.

Verification
REQ-031 Single sample I=0x123456, Q=0xABCDEF, out_ready=1 -> out_valid in cycle N+2, then bytes 12,34,56,AB,CD,EF on consecutive cycles, out_last on EF, then out_valid=0.
REQ-032 Three strobes 2 cycles apart, out_ready=1 -> 18 contiguous bytes in input order, no gap between samples, level never exceeds 2.
REQ-033 out_ready=0 with DEPTH+2 strobes -> first sample held at byte 0, level=DEPTH, overflow=1 after strobe DEPTH+2; release ready -> exactly DEPTH+1 samples emerge (the shift-register sample plus DEPTH queued).
REQ-034 out_ready toggling 1,0,1,0 across a sample -> each byte held stable while ready=0; sequence unchanged.
REQ-035 Reset asserted at byte index 3 with 2 samples queued -> next cycle out_valid=0 and level=0; new strobe after reset -> REQ-023 timing.
REQ-036 clear_ovf coincident with a drop -> overflow stays 1; clear_ovf alone next cycle -> overflow=0.
